// File: rtl/button_gesture_pkg.sv
// Shared state encoding for the button gesture classifier.
// The debug/LED display logic decodes state_dbg with these values.
package button_gesture_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    HELD   = 3'd4
  } state_e;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/gesture_timer.sv
// Tick-qualified saturating counter with synchronous clear
// and a terminal-count match against a per-state compare value.
module gesture_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick_i,
  input  logic          clr_i,
  input  logic [CW-1:0] term_i,
  output logic          match_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (tick_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_o = tick_i && (cnt_q == term_i);

endmodule

// File: rtl/button_gesture.sv
// Short/double/long press classifier with registered one-cycle pulses.
// Auto-repeat while held is built only with BUTTON_GESTURE_AUTOREPEAT_EN.
module button_gesture
  import button_gesture_pkg::*;
#(
  parameter int LONG_TICKS   = 8,
  parameter int GAP_TICKS    = 4,
  parameter int REPEAT_TICKS = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               btn_level,
  output logic               short_press,
  output logic               double_press,
  output logic               long_press,
  output logic               repeat_pulse,
  output logic [STATE_W-1:0] state_dbg
);

  localparam int MAXT = max3(LONG_TICKS, GAP_TICKS, REPEAT_TICKS);
  localparam int CW   = $clog2(MAXT) + 1;

  localparam logic [CW-1:0] LONG_T = CW'(LONG_TICKS - 1);
  localparam logic [CW-1:0] GAP_T  = CW'(GAP_TICKS - 1);
`ifdef BUTTON_GESTURE_AUTOREPEAT_EN
  localparam logic [CW-1:0] REP_T  = CW'(REPEAT_TICKS - 1);
`endif

  state_e        state_q, state_d;
  logic          short_q, short_d;
  logic          double_q, double_d;
  logic          long_q, long_d;
  logic          rep_q, rep_d;
  logic          rep_clr;
  logic [CW-1:0] term;
  logic          match;
  logic          clr;

  gesture_timer #(.CW(CW)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .tick_i  (tick),
    .clr_i   (clr),
    .term_i  (term),
    .match_o (match)
  );

  // Button edges are tested first so they win over a coincident timeout
  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    rep_d    = 1'b0;
    rep_clr  = 1'b0;
    term     = '0;
    case (state_q)
      IDLE: begin
        if (btn_level) state_d = PRESS1;
      end
      PRESS1: begin
        term = LONG_T;
        if (!btn_level) begin
          state_d = WAIT2;
        end else if (match) begin
          state_d = HELD;
          long_d  = 1'b1;
        end
      end
      WAIT2: begin
        term = GAP_T;
        if (btn_level) begin
          state_d  = PRESS2;
          double_d = 1'b1;
        end else if (match) begin
          state_d = IDLE;
          short_d = 1'b1;
        end
      end
      PRESS2: begin
        if (!btn_level) state_d = IDLE;
      end
      HELD: begin
`ifdef BUTTON_GESTURE_AUTOREPEAT_EN
        term = REP_T;
        if (!btn_level) begin
          state_d = IDLE;
        end else if (match) begin
          rep_d   = 1'b1;
          rep_clr = 1'b1;
        end
`else
        if (!btn_level) state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign clr = (state_d != state_q) || rep_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      rep_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      short_q  <= short_d;
      double_q <= double_d;
      long_q   <= long_d;
      rep_q    <= rep_d;
    end
  end

  assign short_press  = short_q;
  assign double_press = double_q;
  assign long_press   = long_q;
  assign state_dbg    = state_q;

`ifdef BUTTON_GESTURE_AUTOREPEAT_EN
  assign repeat_pulse = rep_q;
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule
